// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans the enabled inputs of an external 4:1 mux.
// A channel is selected, sel is held for SETTLE cycles so the mux output
// can settle, and the sample is then captured and offered downstream on a
// valid/ready port. The selection pointer rotates past each delivered
// channel so enabled channels are visited round-robin.
//
// Handshake: out_valid rises only in HOLD, together with out_data/out_ch.
// While out_valid=1 and out_ready=0, out_valid, out_data, out_ch and sel hold.
// A beat transfers on a rising edge where out_valid and out_ready are both 1.
// out_valid does not depend on out_ready.
module mux_scan_ctrl #(
   parameter int DW     = 4,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [3:0]    mask,
   output logic [1:0]    sel,
   input  logic [DW-1:0] mux_out,
   output logic [DW-1:0] out_data,
   output logic [1:0]    out_ch,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   // Reload value of the settle counter; SETTLE is expected in 1..15.
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [1:0]    out_ch_q, out_ch_d;
   logic          out_valid_q, out_valid_d;

   logic [1:0]    ptr_after;
   logic          scan_req;

   // First index with its mask bit set, searched start, start+1, ... mod 4.
   // Iterating from the farthest offset down lets the nearest hit win.
   function automatic logic [1:0] next_ch(input logic [1:0] start,
                                          input logic [3:0] m);
      logic [1:0] res;
      logic [1:0] idx;
      res = start;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (m[idx]) begin
            res = idx;
         end
      end
      return res;
   endfunction

   // Pointer value once the held channel is delivered, and scan request.
   always_comb begin
      ptr_after = out_ch_q + 2'd1;
      scan_req  = en && (mask != 4'd0);
   end

   // Next-state and datapath: select, settle, capture, hand off.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (scan_req) begin
               sel_d   = next_ch(ptr_q, mask);
               cnt_d   = SETTLE_LD;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            // <= 1 so a corrupted zero count still terminates the settle.
            if (cnt_q <= 4'd1) begin
               cnt_d       = 4'd0;
               out_data_d  = mux_out;
               out_ch_d    = sel_q;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               ptr_d       = ptr_after;
               out_valid_d = 1'b0;
               if (scan_req) begin
                  sel_d   = next_ch(ptr_after, mask);
                  cnt_d   = SETTLE_LD;
                  state_d = S_SETTLE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State registers; synchronous reset discards any in-flight sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel_q       <= 2'd0;
         ptr_q       <= 2'd0;
         cnt_q       <= 4'd0;
         out_data_q  <= '0;
         out_ch_q    <= 2'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Output mapping.
   always_comb begin
      sel       = sel_q;
      out_data  = out_data_q;
      out_ch    = out_ch_q;
      out_valid = out_valid_q;
      busy      = (state_q != S_IDLE);
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl (DW=4, SETTLE=1). The external mux is modelled
// as channel i driving value i+1.
module tb_mux_scan_ctrl;

   localparam int DW      = 4;
   localparam int EXP_GAP = 2;   // cycles between beats when ready stays high
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic          clk;
   logic          rst;
   logic          en;
   logic [3:0]    mask;
   logic [1:0]    sel;
   logic [DW-1:0] mux_out;
   logic [DW-1:0] out_data;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [1:0]    state_dbg;

   int checks = 0;
   int errors = 0;
   int beats  = 0;
   int cyc    = 0;
   int last_beat_cyc = 0;
   logic have_prev = 1'b0;
   logic gap_chk   = 1'b0;

   logic [5:0] exp_q[$];   // {ch, data}

   mux_scan_ctrl #(.DW(DW), .SETTLE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mask      (mask),
      .sel       (sel),
      .mux_out   (mux_out),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Downstream mux model: channel i carries i+1.
   assign mux_out = 4'(sel) + 4'd1;

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input logic [1:0] ch, input logic [3:0] data);
      exp_q.push_back({ch, data});
   endtask

   // Monitor: at the falling edge, a beat that will transfer on the next
   // rising edge is popped from the queue and compared.
   always @(negedge clk) begin
      if (out_valid) begin
         check("valid_only_in_hold", 32'(state_dbg), 32'(ST_HOLD));
      end
      if (!rst && out_valid && out_ready) begin
         beats++;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'({out_ch, out_data}), 32'h0);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("beat_ch", 32'(out_ch), 32'(e[5:4]));
            check("beat_data", 32'(out_data), 32'(e[3:0]));
         end
         if (gap_chk && have_prev) begin
            check("beat_gap", 32'(cyc - last_beat_cyc), 32'(EXP_GAP));
         end
         have_prev     = 1'b1;
         last_beat_cyc = cyc;
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; mask = 4'd0; out_ready = 1'b0;
      cycles(2);
      rst = 1'b0;
      // Reset state.
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);

      // Full mask round-robin: ch 0,1,2,3,0 with data 1,2,3,4,1.
      expect_beat(2'd0, 4'd1); expect_beat(2'd1, 4'd2); expect_beat(2'd2, 4'd3);
      expect_beat(2'd3, 4'd4); expect_beat(2'd0, 4'd1);
      mask = 4'b1111; out_ready = 1'b1; en = 1'b1; gap_chk = 1'b1; have_prev = 1'b0;
      cycles(1);
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_valid_lo", 32'(out_valid), 32'd0);
      check("lat_sel", 32'(sel), 32'd0);
      cycles(1);
      check("lat_valid_hi", 32'(out_valid), 32'd1);
      cycles(8);
      en = 1'b0;
      cycles(3);
      check("rr_idle", 32'(busy), 32'd0);
      check("rr_drained", 32'(exp_q.size()), 32'd0);

      // Sparse mask 1010: channels 1,3,1,3; sel never 0 or 2.
      expect_beat(2'd1, 4'd2); expect_beat(2'd3, 4'd4);
      expect_beat(2'd1, 4'd2); expect_beat(2'd3, 4'd4);
      mask = 4'b1010; en = 1'b1; have_prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycles(1);
         check("sparse_sel_odd", 32'(sel[0]), 32'd1);
      end
      en = 1'b0;
      cycles(3);
      gap_chk = 1'b0;
      check("sparse_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure in HOLD, then one transfer and a SETTLE-cycle gap.
      expect_beat(2'd2, 4'd3); expect_beat(2'd2, 4'd3);
      mask = 4'b0100; out_ready = 1'b0; en = 1'b1;
      cycles(2);
      for (int i = 0; i < 5; i++) begin
         cycles(1);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'd3);
         check("hold_ch", 32'(out_ch), 32'd2);
         check("hold_sel", 32'(sel), 32'd2);
      end
      out_ready = 1'b1;
      cycles(1);
      out_ready = 1'b0;
      check("gap_valid_lo", 32'(out_valid), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      cycles(1);
      check("gap_valid_hi", 32'(out_valid), 32'd1);
      en = 1'b0; out_ready = 1'b1;
      cycles(1);
      check("bp_idle", 32'(busy), 32'd0);
      check("bp_drained", 32'(exp_q.size()), 32'd0);

      // en and mask drop mid-SETTLE: sample still delivered (ptr 3 -> ch 0).
      expect_beat(2'd0, 4'd1);
      out_ready = 1'b0; mask = 4'b0001; en = 1'b1;
      cycles(1);
      check("abort_busy", 32'(busy), 32'd1);
      en = 1'b0; mask = 4'b0000;
      cycles(1);
      check("abort_valid", 32'(out_valid), 32'd1);
      check("abort_ch", 32'(out_ch), 32'd0);
      out_ready = 1'b1;
      cycles(1);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_valid_lo", 32'(out_valid), 32'd0);

      // Reset during HOLD discards the sample (ptr 1, mask 1000 -> ch 3).
      out_ready = 1'b0; mask = 4'b1000; en = 1'b1;
      cycles(2);
      check("rsthold_valid", 32'(out_valid), 32'd1);
      check("rsthold_ch", 32'(out_ch), 32'd3);
      rst = 1'b1;
      cycles(1);
      check("rsthold_valid_lo", 32'(out_valid), 32'd0);
      check("rsthold_sel", 32'(sel), 32'd0);
      check("rsthold_busy", 32'(busy), 32'd0);
      check("rsthold_data", 32'(out_data), 32'd0);
      cycles(1);
      check("rst_overrides_en", 32'(busy), 32'd0);
      expect_beat(2'd2, 4'd3);
      rst = 1'b0; mask = 4'b0100; out_ready = 1'b1;
      cycles(2);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_ch", 32'(out_ch), 32'd2);
      en = 1'b0;
      cycles(2);

      // mask=0 with en=1 stays idle; then mask 0001 (ptr 3 wraps to ch 0).
      mask = 4'b0000; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         check("m0_busy", 32'(busy), 32'd0);
         check("m0_valid", 32'(out_valid), 32'd0);
      end
      expect_beat(2'd0, 4'd1);
      mask = 4'b0001;
      cycles(1);
      check("m1_valid_lo", 32'(out_valid), 32'd0);
      cycles(1);
      check("m1_valid_hi", 32'(out_valid), 32'd1);
      check("m1_ch", 32'(out_ch), 32'd0);
      en = 1'b0;
      cycles(3);

      check("final_drained", 32'(exp_q.size()), 32'd0);
      check("final_beats", 32'(beats), 32'd14);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
